// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes, FSM state encoding and unit counts.
package morse_pkg;

  // Symbol codes exchanged between the decoder and the encoder.
  typedef enum logic [2:0] {
    SymDit  = 3'd1,
    SymDah  = 3'd2,
    SymLgap = 3'd3,
    SymWgap = 3'd4
  } morse_sym_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMark  = 2'd1,
    StSpace = 2'd2
  } morse_state_e;

  localparam int unsigned UnitsW = 3;

  localparam logic [UnitsW-1:0] DitUnits   = 3'd1;
  localparam logic [UnitsW-1:0] DahUnits   = 3'd3;
  localparam logic [UnitsW-1:0] LgapUnits  = 3'd2;
  localparam logic [UnitsW-1:0] WgapUnits  = 3'd6;
  // Gap inserted after every mark.
  localparam logic [UnitsW-1:0] IntraUnits = 3'd1;

  function automatic logic sym_legal(logic [2:0] code);
    return (code == SymDit) || (code == SymDah) || (code == SymLgap) || (code == SymWgap);
  endfunction

  function automatic logic sym_is_mark(logic [2:0] code);
    return (code == SymDit) || (code == SymDah);
  endfunction

  function automatic logic [UnitsW-1:0] sym_units(logic [2:0] code);
    logic [UnitsW-1:0] units;
    units = '0;
    if (code == SymDit)  units = DitUnits;
    if (code == SymDah)  units = DahUnits;
    if (code == SymLgap) units = LgapUnits;
    if (code == SymWgap) units = WgapUnits;
    return units;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Synchronous show-ahead FIFO for buffered Morse symbols.
module sym_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Guard both ports so the FIFO can never overflow or underflow.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/dit_dah_encoder.sv
// Morse keyer: turns buffered dit/dah/gap symbols into a timed on/off keyed line.
module dit_dah_encoder #(
  parameter int unsigned UNIT_CYCLES = 33,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ditsdahs,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       signal,
  output logic       busy,
  output logic       err
);

  import morse_pkg::*;

  localparam int unsigned CntW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  UnitReload = 8'(UNIT_CYCLES - 1);

  logic             accept, legal;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2:0]       fifo_rdata;
  logic [CntW-1:0]  fifo_count;

  morse_state_e      state_q, state_d;
  logic [7:0]        unit_cnt_q, unit_cnt_d;
  logic [UnitsW-1:0] units_left_q, units_left_d;
  logic              signal_q, err_q;
  logic              load;

  assign sym_ready = !fifo_full;
  assign accept    = sym_valid && sym_ready;
  assign legal     = sym_legal(ditsdahs);
  // Illegal codes are handshaken but never buffered.
  assign fifo_push = accept && legal;

  sym_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (3)
  ) u_sym_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .wdata_i (ditsdahs),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state: count down cycles and units, chain symbols without an idle bubble.
  always_comb begin
    state_d      = state_q;
    unit_cnt_d   = unit_cnt_q;
    units_left_d = units_left_q;
    fifo_pop     = 1'b0;
    load         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) load = 1'b1;
      end
      StMark, StSpace: begin
        if (unit_cnt_q != 8'd0) begin
          unit_cnt_d = unit_cnt_q - 8'd1;
        end else if (units_left_q != '0) begin
          units_left_d = units_left_q - 1'b1;
          unit_cnt_d   = UnitReload;
        end else if (state_q == StMark) begin
          state_d      = StSpace;
          unit_cnt_d   = UnitReload;
          units_left_d = IntraUnits - 1'b1;
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d      = StIdle;
          unit_cnt_d   = 8'd0;
          units_left_d = '0;
        end
      end
      default: begin
        state_d      = StIdle;
        unit_cnt_d   = 8'd0;
        units_left_d = '0;
      end
    endcase

    if (load) begin
      fifo_pop     = 1'b1;
      state_d      = sym_is_mark(fifo_rdata) ? StMark : StSpace;
      unit_cnt_d   = UnitReload;
      units_left_d = sym_units(fifo_rdata) - 1'b1;
    end
  end

  // State, counters and registered outputs; reset kills any mark in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      unit_cnt_q   <= 8'd0;
      units_left_q <= '0;
      signal_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_cnt_q   <= unit_cnt_d;
      units_left_q <= units_left_d;
      signal_q     <= (state_d == StMark);
      err_q        <= accept && !legal;
    end
  end

  assign signal = signal_q;
  assign err    = err_q;
  assign busy   = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_dit_dah_encoder.sv
// Directed bench: expected keyed-line runs are queued per accepted symbol and
// compared run by run as the encoder produces them.
`timescale 1ns/1ps
module tb_dit_dah_encoder;

  localparam int unsigned Unit  = 4;
  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ditsdahs = 3'd0;
  logic       sym_valid = 1'b0;
  logic       sym_ready, signal, busy, err;

  always #5 clk = ~clk;

  dit_dah_encoder #(
    .UNIT_CYCLES (Unit),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ditsdahs  (ditsdahs),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .signal    (signal),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    logic lvl;
    int   len;
  } seg_t;

  seg_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic in_sess = 1'b0;
  logic cur_lvl = 1'b0;
  int   cur_len = 0;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic add_seg(input logic lvl, input int len);
    seg_t t;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].lvl == lvl) begin
      t = exp_q.pop_back();
      t.len += len;
      exp_q.push_back(t);
    end else begin
      t.lvl = lvl;
      t.len = len;
      exp_q.push_back(t);
    end
  endtask

  // Expected line behaviour contributed by one accepted legal symbol.
  task automatic model_sym(input logic [2:0] code);
    // From idle the first busy cycle is the pop cycle, still low.
    if (!busy) add_seg(1'b0, 1);
    case (code)
      3'd1: begin add_seg(1'b1, Unit);     add_seg(1'b0, Unit); end
      3'd2: begin add_seg(1'b1, 3 * Unit); add_seg(1'b0, Unit); end
      3'd3: add_seg(1'b0, 2 * Unit);
      3'd4: add_seg(1'b0, 6 * Unit);
      default: ;
    endcase
  endtask

  task automatic finish_run();
    seg_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_run_len", cur_len, 0);
    end else begin
      e = exp_q.pop_front();
      check("run_level", int'(cur_lvl), int'(e.lvl));
      check("run_len", cur_len, e.len);
    end
  endtask

  task automatic monitor();
    if (!in_sess) begin
      if (busy) begin
        in_sess = 1'b1;
        cur_lvl = signal;
        cur_len = 1;
      end else if (signal) begin
        check("signal_while_idle", int'(signal), 0);
      end
    end else if (busy) begin
      if (signal === cur_lvl) begin
        cur_len++;
      end else begin
        finish_run();
        cur_lvl = signal;
        cur_len = 1;
      end
    end else begin
      finish_run();
      in_sess = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic push_sym(input logic [2:0] code, output int stalls);
    sym_valid = 1'b1;
    ditsdahs  = code;
    stalls    = 0;
    while (!sym_ready && stalls < 200) begin
      tick();
      stalls++;
    end
    if (!sym_ready) begin
      check("push_timeout_ready", int'(sym_ready), 1);
    end else if (code >= 3'd1 && code <= 3'd4) begin
      model_sym(code);
    end
    tick();
    sym_valid = 1'b0;
    ditsdahs  = 3'd0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || in_sess || exp_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    check("pending_runs", exp_q.size(), 0);
    check("busy_after_drain", int'(busy), 0);
    check("signal_after_drain", int'(signal), 0);
  endtask

  initial begin
    int st;
    int stalls [6];
    int hi;
    int n;

    // Reset state
    tick();
    tick();
    check("rst_ready", int'(sym_ready), 1);
    check("rst_signal", int'(signal), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    tick();

    // Single dit
    push_sym(3'd1, st);
    check("dit_ready_after_accept", int'(sym_ready), 1);
    tick();
    check("dit_first_edge_high", int'(signal), 1);
    wait_idle(100);

    // Letter A followed by a letter gap
    push_sym(3'd1, st);
    push_sym(3'd2, st);
    push_sym(3'd3, st);
    wait_idle(200);

    // Word gap between two dits: 28 low cycles
    push_sym(3'd1, st);
    push_sym(3'd4, st);
    push_sym(3'd1, st);
    wait_idle(300);

    // Full FIFO with sym_valid held: sixth dah waits for the first pop
    for (int i = 0; i < 6; i++) begin
      push_sym(3'd2, st);
      stalls[i] = st;
      if (i == 4) check("full_ready_low", int'(sym_ready), 0);
    end
    for (int i = 0; i < 5; i++) check("full_no_stall", stalls[i], 0);
    check("full_sixth_stall", stalls[5], 3 * Unit + Unit + 1 - 4);
    wait_idle(600);

    // Illegal codes: one-cycle err, nothing buffered
    push_sym(3'd6, st);
    check("ill6_err", int'(err), 1);
    check("ill6_busy", int'(busy), 0);
    check("ill6_ready", int'(sym_ready), 1);
    tick();
    check("ill6_err_clear", int'(err), 0);
    check("ill6_signal", int'(signal), 0);
    push_sym(3'd0, st);
    check("ill0_err", int'(err), 1);
    tick();
    check("ill0_err_clear", int'(err), 0);
    check("ill0_busy", int'(busy), 0);

    // Reset in the middle of a dah with more symbols buffered
    push_sym(3'd2, st);
    push_sym(3'd2, st);
    push_sym(3'd1, st);
    hi = 0;
    n  = 0;
    while (hi < 6 && n < 100) begin
      tick();
      if (signal) hi++;
      n++;
    end
    check("mid_dah_high_cycles", hi, 6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_signal", int'(signal), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(sym_ready), 1);
    check("mid_rst_err", int'(err), 0);
    exp_q.delete();
    in_sess = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_signal", int'(signal), 0);

    // Clean start after reset
    push_sym(3'd1, st);
    wait_idle(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
